// File: rtl/dmem_if.sv
// Data-memory request/response bundle between the load/store aligner
// and the memory-side responder.
interface dmem_if;
  logic        req_valid;
  logic        req_ready;
  logic [29:0] address;
  logic [3:0]  write_flag;
  logic [31:0] write_data;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] read_output;

  modport master (
    output req_valid, address, write_flag, write_data,
    input  req_ready, resp_valid, resp_err, read_output
  );

  modport slave (
    input  req_valid, address, write_flag, write_data,
    output req_ready, resp_valid, resp_err, read_output
  );
endinterface

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder: byte-lane writes commit at
// accept, reads return after READ_LATENCY cycles, misses answer with err.
module dmem_responder #(
  parameter logic [31:0] DMEM_BASE    = 32'h0010_0000,
  parameter int          DMEM_SIZE    = 32768,
  parameter string       INIT_FILE    = "target/data.mif",
  parameter int          READ_LATENCY = 2
) (
  input logic   clk,
  input logic   rst,
  dmem_if.slave bus
);
  localparam int WORDS = DMEM_SIZE / 4;
  localparam int IW = $clog2(WORDS);
  localparam logic [3:0] LAT_M1 = 4'(READ_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    READ_WAIT,
    RESP
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [3:0]    cnt;
  logic          hit_q;
  logic [IW-1:0] idx_q;
  logic [31:0]   rdata_q;
  logic [31:0]   mem [WORDS];

  logic          hit;
  logic          accept;
  logic          is_wr;
  logic          capture;
  logic          cap_hit;
  logic [IW-1:0] idx;
  logic [IW-1:0] cap_idx;

  assign idx = bus.address[IW-1:0];
  assign hit = (bus.address[29:18] == DMEM_BASE[31:20])
            && ({14'd0, bus.address[17:0]} < 32'(WORDS));
  assign is_wr = |bus.write_flag;
  assign accept = bus.req_valid && bus.req_ready;

  assign bus.req_ready = (state == IDLE) && !rst;
  assign bus.resp_valid = (state == RESP);
  assign bus.resp_err = (state == RESP) && !hit_q;
  assign bus.read_output = rdata_q;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (is_wr || READ_LATENCY == 1) state_nxt = RESP;
          else state_nxt = READ_WAIT;
        end
      end
      READ_WAIT: if (cnt <= 4'd1) state_nxt = RESP;
      RESP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Read data is sampled on the edge that enters RESP; with a one-cycle
  // latency that edge is the accept edge, so use the live request.
  always_comb begin
    capture = 1'b0;
    cap_hit = hit_q;
    cap_idx = idx_q;
    if (state == IDLE) begin
      capture = accept && !is_wr && (READ_LATENCY == 1);
      cap_hit = hit;
      cap_idx = idx;
    end else if (state == READ_WAIT) begin
      capture = (cnt <= 4'd1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= 4'd0;
      hit_q <= 1'b0;
      idx_q <= '0;
      rdata_q <= 32'h0;
    end else begin
      if (accept) begin
        hit_q <= hit;
        idx_q <= idx;
        cnt <= is_wr ? 4'd0 : LAT_M1;
      end else if (state == READ_WAIT) begin
        cnt <= cnt - 4'd1;
      end
      if (capture) rdata_q <= cap_hit ? mem[cap_idx] : 32'h0;
    end
  end

  // Storage is not reset so contents survive a mid-operation reset.
  always_ff @(posedge clk) begin
    if (accept && is_wr && hit) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.write_flag[i]) mem[idx][8*i +: 8] <= bus.write_data[8*i +: 8];
      end
    end
  end
endmodule
